fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Instruction buffer between fetch and the per-format decoders (D/DS/DQ/X/...).
- Accepts one 32-bit instruction per cycle from fetch and stores it with its effective address in a small FIFO.
- Presents one registered instruction per cycle, with a valid strobe, to all format decoders in parallel; the addressed decoder claims it by primary opcode.
- Absorbs decoder stall back-pressure and pushes it back to fetch as a full flag. Supports flush on branch redirect.

Parameters:
- instructionWidth, 32, instruction word width
- addressWidth, 64, instruction effective-address width
- queueDepth, 4, FIFO entries; excludes the output register
- queueIndexWidth, 2, log2(queueDepth)
- opcodeWidth, 6, primary opcode field width

Ports:
- clock_i  input  1  clock, rising edge
- reset_i  input  1  synchronous, active-low reset
- fetchEnable_i  input  1  instruction_i/instructionAddress_i valid this cycle
- instruction_i  input  [0:instructionWidth-1]  fetched instruction, bit 0 = MSB
- instructionAddress_i  input  [0:addressWidth-1]  instruction address
- stall_i  input  1  OR of decoder stall_o; hold output
- flush_i  input  1  discard all buffered and presented instructions
- queueFull_o  output  1  FIFO holds queueDepth entries; fetch must not push
- count_o  output  [0:queueIndexWidth]  FIFO occupancy, 0..queueDepth
- overflow_o  output  1  sticky: a push was dropped because the FIFO was full
- enable_o  output  1  instruction_o valid; drives decoder enable_i
- instruction_o  output  [0:instructionWidth-1]  presented instruction
- instructionAddress_o  output  [0:addressWidth-1]  presented address
- opcode_o  output  [0:opcodeWidth-1]  instruction_o[0:5], registered with it

Behaviour:
- Reset (reset_i=0 at a rising edge) has priority over everything:
  - count, head and tail pointers cleared.
  - enable_o, overflow_o, instruction_o, instructionAddress_o and opcode_o all 0.
  - queueFull_o=0, count_o=0.
- Flush (flush_i=1, reset inactive), for one cycle:
  - FIFO emptied, enable_o<=0.
  - A same-cycle push is discarded and does not set overflow_o.
  - instruction_o, instructionAddress_o and opcode_o hold their last value.
  - overflow_o is unchanged.
- queueFull_o and count_o come combinationally from the registered count. queueFull_o = (count==queueDepth).
- Push rule, evaluated on the count at the start of the cycle:
  - fetchEnable_i=1 with count<queueDepth: entry written at tail, tail increments mod queueDepth.
  - fetchEnable_i=1 with count==queueDepth: input dropped and overflow_o<=1. This holds even if a pop occurs the same cycle; there is no full-bypass.
- Output stage, stall_i=0:
  - FIFO non-empty: head entry loaded into the output registers, enable_o<=1, head increments mod queueDepth (pop).
  - FIFO empty and fetchEnable_i=1: input bypasses the FIFO directly into the output registers, enable_o<=1. Nothing is written to the FIFO and count is unchanged.
  - FIFO empty and fetchEnable_i=0: enable_o<=0. Data registers hold.
- Output stage, stall_i=1:
  - Output registers and enable_o hold; no pop.
  - Pushes proceed per the push rule (no bypass).
- Count update: count += push − pop. Push and pop in the same cycle leaves count unchanged; pointers still advance.
- Latency:
  - Empty queue, no stall: fetchEnable_i at cycle N gives enable_o=1 at cycle N+1.
  - Otherwise FIFO order is preserved; the output always presents the oldest unconsumed instruction.
- Ordering invariant: bypass only when count==0. A bypassed instruction can never overtake a buffered one.
- Pointer wrap: both pointers wrap from queueDepth-1 to 0. Full and empty are distinguished by count, not by pointer equality.
- opcode_o is always instruction_o[0:opcodeWidth-1], loaded in the same cycle.
- overflow_o clears only on reset.

Test Plan:
- Reset, then fetchEnable_i=1 with instruction_i=0xE0000000 (opcode 56), address 0x100, stall_i=0 → next cycle: enable_o=1, instruction_o=0xE0000000, opcode_o=56, address 0x100, count_o=0.
- Hold stall_i=1 while pushing 5 instructions A..E on consecutive cycles, output empty at start:
  - A..D buffered, count_o=4, queueFull_o=1.
  - E dropped, overflow_o=1.
  - enable_o stays 0 throughout.
- Release stall_i with no further pushes → A, B, C, D presented on 4 consecutive cycles, enable_o=1 each. Then enable_o=0, count_o=0; pointers have wrapped to 0.
- Fill to count 2, then fetchEnable_i=1 and stall_i=0 every cycle → order preserved, no bypass while count>0. count_o stays 2 (push+pop) until fetch stops.
- Count 3 with enable_o=1, assert flush_i together with fetchEnable_i=1 (0xF4000001) → next cycle count_o=0, enable_o=0, overflow_o unchanged. The next push then reappears at the output after 1 cycle.
- Assert reset_i=0 mid-stream with count 4 and overflow_o=1 → next cycle all outputs 0. Deassert and push 0xF4000001 → enable_o=1, opcode_o=61 one cycle later.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Instruction buffer between fetch and the format decoders: a small FIFO plus a
// registered presentation stage, with empty-queue bypass, stall hold and flush.
module fetch_decode_queue #(
    parameter int instructionWidth = 32,
    parameter int addressWidth     = 64,
    parameter int queueDepth       = 4,
    parameter int queueIndexWidth  = 2,
    parameter int opcodeWidth      = 6
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        fetchEnable_i,
    input  logic [0:instructionWidth-1] instruction_i,
    input  logic [0:addressWidth-1]     instructionAddress_i,
    input  logic                        stall_i,
    input  logic                        flush_i,
    output logic                        queueFull_o,
    output logic [0:queueIndexWidth]    count_o,
    output logic                        overflow_o,
    output logic                        enable_o,
    output logic [0:instructionWidth-1] instruction_o,
    output logic [0:addressWidth-1]     instructionAddress_o,
    output logic [0:opcodeWidth-1]      opcode_o
);

    localparam logic [queueIndexWidth:0]   depth_c    = (queueIndexWidth+1)'(queueDepth);
    localparam logic [queueIndexWidth:0]   cnt_zero_c = (queueIndexWidth+1)'(0);
    localparam logic [queueIndexWidth:0]   cnt_one_c  = (queueIndexWidth+1)'(1);
    localparam logic [queueIndexWidth-1:0] ptr_zero_c = queueIndexWidth'(0);
    localparam logic [queueIndexWidth-1:0] ptr_one_c  = queueIndexWidth'(1);
    localparam logic [queueIndexWidth-1:0] ptr_last_c = queueIndexWidth'(queueDepth - 1);

    logic [0:instructionWidth-1] instr_mem_q [queueDepth];
    logic [0:instructionWidth-1] instr_mem_d [queueDepth];
    logic [0:addressWidth-1]     addr_mem_q  [queueDepth];
    logic [0:addressWidth-1]     addr_mem_d  [queueDepth];

    logic [queueIndexWidth-1:0]  head_q, head_d;
    logic [queueIndexWidth-1:0]  tail_q, tail_d;
    logic [queueIndexWidth:0]    count_q, count_d;
    logic                        enable_q, enable_d;
    logic                        overflow_q, overflow_d;
    logic [0:instructionWidth-1] instr_out_q, instr_out_d;
    logic [0:addressWidth-1]     addr_out_q, addr_out_d;
    logic [0:opcodeWidth-1]      opcode_q, opcode_d;

    logic full_s, empty_s, pop_s, bypass_s, push_s, drop_s;

    // Pointers wrap explicitly so a non-power-of-two depth still works.
    function automatic logic [queueIndexWidth-1:0] next_ptr(input logic [queueIndexWidth-1:0] ptr);
        logic [queueIndexWidth-1:0] nxt;
        if (ptr == ptr_last_c) begin
            nxt = ptr_zero_c;
        end else begin
            nxt = ptr + ptr_one_c;
        end
        return nxt;
    endfunction

    // Next-state logic for FIFO, presentation registers and sticky overflow.
    always_comb begin
        instr_mem_d = instr_mem_q;
        addr_mem_d  = addr_mem_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        enable_d    = enable_q;
        overflow_d  = overflow_q;
        instr_out_d = instr_out_q;
        addr_out_d  = addr_out_q;
        opcode_d    = opcode_q;

        full_s   = (count_q == depth_c);
        empty_s  = (count_q == cnt_zero_c);
        pop_s    = !stall_i && !empty_s;
        // Bypass only from an empty queue, so it can never overtake buffered work.
        bypass_s = !stall_i && empty_s && fetchEnable_i;
        push_s   = fetchEnable_i && !full_s && !bypass_s;
        drop_s   = fetchEnable_i && full_s;

        if (flush_i) begin
            head_d   = ptr_zero_c;
            tail_d   = ptr_zero_c;
            count_d  = cnt_zero_c;
            enable_d = 1'b0;
        end else begin
            if (push_s) begin
                instr_mem_d[tail_q] = instruction_i;
                addr_mem_d[tail_q]  = instructionAddress_i;
                tail_d              = next_ptr(tail_q);
            end else begin
                tail_d = tail_q;
            end

            if (pop_s) begin
                instr_out_d = instr_mem_q[head_q];
                addr_out_d  = addr_mem_q[head_q];
                opcode_d    = instr_mem_q[head_q][0:opcodeWidth-1];
                enable_d    = 1'b1;
                head_d      = next_ptr(head_q);
            end else if (bypass_s) begin
                instr_out_d = instruction_i;
                addr_out_d  = instructionAddress_i;
                opcode_d    = instruction_i[0:opcodeWidth-1];
                enable_d    = 1'b1;
            end else if (!stall_i) begin
                enable_d = 1'b0;
            end else begin
                enable_d = enable_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + cnt_one_c;
                2'b01:   count_d = count_q - cnt_one_c;
                default: count_d = count_q;
            endcase

            if (drop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            for (int i = 0; i < queueDepth; i++) begin
                instr_mem_q[i] <= '0;
                addr_mem_q[i]  <= '0;
            end
            head_q      <= ptr_zero_c;
            tail_q      <= ptr_zero_c;
            count_q     <= cnt_zero_c;
            enable_q    <= 1'b0;
            overflow_q  <= 1'b0;
            instr_out_q <= '0;
            addr_out_q  <= '0;
            opcode_q    <= '0;
        end else begin
            instr_mem_q <= instr_mem_d;
            addr_mem_q  <= addr_mem_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            enable_q    <= enable_d;
            overflow_q  <= overflow_d;
            instr_out_q <= instr_out_d;
            addr_out_q  <= addr_out_d;
            opcode_q    <= opcode_d;
        end
    end

    assign queueFull_o          = (count_q == depth_c);
    assign count_o              = count_q;
    assign overflow_o           = overflow_q;
    assign enable_o             = enable_q;
    assign instruction_o        = instr_out_q;
    assign instructionAddress_o = addr_out_q;
    assign opcode_o             = opcode_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized and directed bench for fetch_decode_queue against a queue-based
// reference model of the buffer's ordering, bypass, flush and overflow rules.
module tb_fetch_decode_queue;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        fetchEnable_i;
    logic [0:31] instruction_i;
    logic [0:63] instructionAddress_i;
    logic        stall_i;
    logic        flush_i;
    logic        queueFull_o;
    logic [0:2]  count_o;
    logic        overflow_o;
    logic        enable_o;
    logic [0:31] instruction_o;
    logic [0:63] instructionAddress_o;
    logic [0:5]  opcode_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] mq_instr[$];
    logic [63:0] mq_addr[$];
    logic        m_en;
    logic        m_ovf;
    logic [31:0] m_instr;
    logic [63:0] m_addr;

    fetch_decode_queue dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .fetchEnable_i        (fetchEnable_i),
        .instruction_i        (instruction_i),
        .instructionAddress_i (instructionAddress_i),
        .stall_i              (stall_i),
        .flush_i              (flush_i),
        .queueFull_o          (queueFull_o),
        .count_o              (count_o),
        .overflow_o           (overflow_o),
        .enable_o             (enable_o),
        .instruction_o        (instruction_o),
        .instructionAddress_o (instructionAddress_o),
        .opcode_o             (opcode_o)
    );

    // Free-running clock
    always #5 clock_i = ~clock_i;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs that were present at the edge.
    task automatic model_edge();
        int  start_size;
        bit  bypassed;
        start_size = mq_instr.size();
        bypassed   = 1'b0;
        if (!reset_i) begin
            mq_instr.delete();
            mq_addr.delete();
            m_en = 1'b0; m_ovf = 1'b0; m_instr = 32'h0; m_addr = 64'h0;
        end else if (flush_i) begin
            mq_instr.delete();
            mq_addr.delete();
            m_en = 1'b0;
        end else begin
            if (!stall_i && start_size > 0) begin
                m_instr = mq_instr.pop_front();
                m_addr  = mq_addr.pop_front();
                m_en    = 1'b1;
            end else if (!stall_i && fetchEnable_i) begin
                m_instr  = instruction_i;
                m_addr   = instructionAddress_i;
                m_en     = 1'b1;
                bypassed = 1'b1;
            end else if (!stall_i) begin
                m_en = 1'b0;
            end
            if (fetchEnable_i && !bypassed) begin
                if (start_size == 4) begin
                    m_ovf = 1'b1;
                end else begin
                    mq_instr.push_back(instruction_i);
                    mq_addr.push_back(instructionAddress_i);
                end
            end
        end
    endtask

    task automatic check_all();
        check_val("enable",   64'(enable_o),             64'(m_en));
        check_val("instr",    64'(instruction_o),        64'(m_instr));
        check_val("addr",     instructionAddress_o,      m_addr);
        check_val("opcode",   64'(opcode_o),             64'(m_instr >> 26));
        check_val("count",    64'(count_o),              64'(mq_instr.size()));
        check_val("full",     64'(queueFull_o),          64'(mq_instr.size() == 4));
        check_val("overflow", 64'(overflow_o),           64'(m_ovf));
    endtask

    task automatic step();
        @(posedge clock_i);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic rst, input logic fe, input logic st, input logic fl,
                         input logic [31:0] ins, input logic [63:0] adr);
        reset_i              = rst;
        fetchEnable_i        = fe;
        stall_i              = st;
        flush_i              = fl;
        instruction_i        = ins;
        instructionAddress_i = adr;
        step();
    endtask

    initial begin
        reset_i = 1'b0; fetchEnable_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        instruction_i = 32'h0; instructionAddress_i = 64'h0;
        m_en = 1'b0; m_ovf = 1'b0; m_instr = 32'h0; m_addr = 64'h0;

        // Reset state
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
        check_val("rst_en", 64'(enable_o), 64'h0);
        check_val("rst_cnt", 64'(count_o), 64'h0);

        // Bypass from empty queue: one-cycle latency
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hE000_0000, 64'h100);
        check_val("byp_en", 64'(enable_o), 64'h1);
        check_val("byp_op", 64'(opcode_o), 64'd56);
        check_val("byp_cnt", 64'(count_o), 64'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);

        // Stall and push A..E: A..D buffered, E dropped
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hA000_0000 + 32'(i), 64'h200 + 64'(4 * i));
        end
        check_val("fill_full", 64'(queueFull_o), 64'h1);
        check_val("fill_ovf", 64'(overflow_o), 64'h1);
        check_val("fill_en", 64'(enable_o), 64'h0);

        // Drain A..D in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
            check_val("drain_ins", 64'(instruction_o), 64'(32'hA000_0000 + 32'(i)));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
        check_val("drain_done", 64'(enable_o), 64'h0);

        // Fill to 2 then stream: count stays 2, order preserved
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0001, 64'h300);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0002, 64'h304);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000_0000 + 32'(i), 64'h400 + 64'(4 * i));
            check_val("stream_cnt", 64'(count_o), 64'h2);
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);

        // Flush with enable_o=1 and count 3, plus a same-cycle push
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h3000_0000, 64'h500);
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h3000_0000 + 32'(i), 64'h500 + 64'(4 * i));
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hF400_0001, 64'h600);
        check_val("flush_cnt", 64'(count_o), 64'h0);
        check_val("flush_en", 64'(enable_o), 64'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h5000_0005, 64'h700);
        check_val("post_flush", 64'(instruction_o), 64'h5000_0005);

        // Reset mid-stream with a full queue and overflow set
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h6000_0000 + 32'(i), 64'h800);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
        check_val("mid_rst_ovf", 64'(overflow_o), 64'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hF400_0001, 64'h900);
        check_val("rst_push_op", 64'(opcode_o), 64'd61);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(199, 0) != 0),
                  ($urandom_range(9, 0) < 7),
                  ($urandom_range(9, 0) < 3),
                  ($urandom_range(39, 0) == 0),
                  $urandom(), {$urandom(), $urandom()});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
